// File: rtl/ble_tx_pkg.sv
// Shared types and constants for the BLE link-layer serializer.
// Channel and RSSI width defaults match the sniffer-wide constants.
package ble_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_AA,
    S_PDU,
    S_GAP
  } state_t;

  localparam int PREAMBLE_BITS = 8;
  localparam int AA_BITS       = 32;
  localparam int PDU_BYTE_BITS = 8;
  localparam int DEF_CHANNEL_W = 7;
  localparam int DEF_RSSI_W    = 8;

endpackage

// File: rtl/ble_serial_tx_timer.sv
// Bit-rate prescaler: tick_o marks the last clock cycle of each on-air bit.
// The count restarts whenever the serializer is not transmitting.
module ble_bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic [CW-1:0] r_cnt;

  assign tick_o = en_i && (r_cnt == CW'(BIT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (!en_i || tick_o) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ble_serial_tx.sv
// BLE link-layer bit serializer: preamble, access address, then PDU bytes,
// each LSB first, followed by a guaranteed idle gap.
module ble_serial_tx
  import ble_tx_pkg::*;
#(
  parameter int CHANNEL_W  = DEF_CHANNEL_W,
  parameter int RSSI_W     = DEF_RSSI_W,
  parameter int LEN_W      = 6,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          aa_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic [CHANNEL_W-1:0] channel_i,
  input  logic [RSSI_W-1:0]    rssi_i,
  input  logic [7:0]           byte_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  output logic                 serial_o,
  output logic                 valid_o,
  output logic [CHANNEL_W-1:0] channel_o,
  output logic [RSSI_W-1:0]    rssi_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  state_t               r_state, w_next;
  logic [31:0]          r_shift;
  logic [LEN_W-1:0]     r_len, r_accepted, r_byteIdx;
  logic [5:0]           r_bitCnt;
  logic [7:0]           r_gapCnt;
  logic [7:0]           r_buf;
  logic                 r_bufFull;
  logic                 r_done, r_err;
  logic [CHANNEL_W-1:0] r_channel;
  logic [RSSI_W-1:0]    r_rssi;

  logic       w_tick, w_active, w_xfer, w_haveByte, w_fieldLast;
  logic       w_load, w_underrun, w_finish;
  logic [7:0] w_nextByte;

  ble_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (w_active),
    .tick_o (w_tick)
  );

  assign w_active = (r_state == S_PRE) || (r_state == S_AA) || (r_state == S_PDU);
  assign byte_ready_o = ((r_state == S_AA) || (r_state == S_PDU)) && !r_bufFull
                        && (r_accepted < r_len);
  assign w_xfer = byte_valid_i && byte_ready_o;
  // A byte arriving in the very load cycle bypasses the buffer instead of underrunning.
  assign w_haveByte = r_bufFull || w_xfer;
  assign w_nextByte = r_bufFull ? r_buf : byte_i;
  assign w_fieldLast = w_tick && (
      ((r_state == S_PRE) && (r_bitCnt == 6'(PREAMBLE_BITS - 1))) ||
      ((r_state == S_AA)  && (r_bitCnt == 6'(AA_BITS - 1))) ||
      ((r_state == S_PDU) && (r_bitCnt == 6'(PDU_BYTE_BITS - 1))));

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_underrun = 1'b0;
    w_finish   = 1'b0;
    unique case (r_state)
      S_IDLE: if (start_i) w_next = S_PRE;
      S_PRE:  if (w_fieldLast) w_next = S_AA;
      S_AA, S_PDU: begin
        if (w_fieldLast) begin
          if ((r_state == S_AA) ? (r_len == '0) : (r_byteIdx == r_len - LEN_W'(1))) begin
            w_next   = S_GAP;
            w_finish = 1'b1;
          end else if (w_haveByte) begin
            w_next = S_PDU;
            w_load = 1'b1;
          end else begin
            w_next     = S_GAP;
            w_underrun = 1'b1;
          end
        end
      end
      S_GAP:  if (r_gapCnt == 8'(GAP_CYCLES - 1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shift    <= '0;
      r_len      <= '0;
      r_accepted <= '0;
      r_byteIdx  <= '0;
      r_bitCnt   <= '0;
      r_gapCnt   <= '0;
      r_buf      <= '0;
      r_bufFull  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_channel  <= '0;
      r_rssi     <= '0;
    end else begin
      r_done   <= w_finish;
      r_err    <= w_underrun;
      r_gapCnt <= ((r_state == S_GAP) && (w_next == S_GAP)) ? r_gapCnt + 8'd1 : 8'd0;
      if (r_state == S_IDLE) begin
        r_bitCnt   <= '0;
        r_byteIdx  <= '0;
        r_accepted <= '0;
        r_bufFull  <= 1'b0;
        if (start_i) begin
          r_shift   <= aa_i;
          r_len     <= len_i;
          r_channel <= channel_i;
          r_rssi    <= rssi_i;
        end
      end else begin
        if (w_tick) begin
          r_bitCnt <= w_fieldLast ? 6'd0 : r_bitCnt + 6'd1;
          if (w_load) r_shift <= {24'd0, w_nextByte};
          else if (r_state != S_PRE) r_shift <= {1'b0, r_shift[31:1]};
          if ((r_state == S_PDU) && w_fieldLast) r_byteIdx <= r_byteIdx + LEN_W'(1);
        end
        if (w_xfer) r_accepted <= r_accepted + LEN_W'(1);
        if (w_load) begin
          r_bufFull <= 1'b0;
        end else if (w_xfer) begin
          r_buf     <= byte_i;
          r_bufFull <= 1'b1;
        end
      end
    end
  end

  // Preamble alternates starting from aa[0], so it always ends opposite the first AA bit.
  assign serial_o  = w_active && ((r_state == S_PRE) ? (r_shift[0] ^ r_bitCnt[0]) : r_shift[0]);
  assign valid_o   = w_active;
  assign busy_o    = (r_state != S_IDLE);
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign channel_o = r_channel;
  assign rssi_o    = r_rssi;

endmodule
